// File: rtl/mastermind_pkg.sv
// Shared definitions for the Mastermind round controller: code geometry,
// controller state encoding, scorer phase encoding and a peg-count helper.
package mastermind_pkg;

  localparam int NUM_PEGS   = 4;
  localparam int COLOR_W    = 3;
  localparam int NUM_COLORS = 6;
  localparam int CODE_W     = NUM_PEGS * COLOR_W;

  typedef enum logic [2:0] {
    ST_START,
    ST_INPUT,
    ST_SCORE_B,
    ST_SCORE_W,
    ST_RESULT,
    ST_DONE_C,
    ST_DONE_NC
  } state_t;

  typedef enum logic [1:0] {
    SC_IDLE,
    SC_BLACK,
    SC_WHITE
  } scorePhase_t;

  // Number of pegs in a packed code that carry the given colour.
  function automatic logic [2:0] countColor(input logic [CODE_W-1:0] code,
                                            input logic [COLOR_W-1:0] color);
    logic [2:0] n;
    n = '0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if (code[p*COLOR_W +: COLOR_W] == color) n = n + 3'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mastermind_scorer.sv
// Sequential Mastermind scorer: four cycles of exact-match (black) counting,
// one peg per cycle, then six cycles of colour-overlap counting, one colour
// per cycle. o_done is raised in the last colour cycle while o_black/o_white
// already include that cycle's contribution, so the caller can register them.
module mastermind_scorer
  import mastermind_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_resetN,
  input  logic              i_start,
  input  logic [CODE_W-1:0] i_guess,
  input  logic [CODE_W-1:0] i_answer,
  output logic              o_blackDone,
  output logic              o_done,
  output logic [2:0]        o_black,
  output logic [2:0]        o_white
);

  scorePhase_t r_phase;
  logic [2:0]  r_idx;
  logic [2:0]  r_black;
  logic [2:0]  r_sum;

  logic        w_pegMatch;
  logic [2:0]  w_guessCnt;
  logic [2:0]  w_ansCnt;
  logic [2:0]  w_minCnt;
  logic [2:0]  w_sumNext;

  // Per-cycle contributions: peg r_idx for black, colour r_idx for overlap.
  always_comb begin
    w_pegMatch = (i_guess[r_idx[1:0]*COLOR_W +: COLOR_W] ==
                  i_answer[r_idx[1:0]*COLOR_W +: COLOR_W]);
    w_guessCnt = countColor(i_guess, r_idx);
    w_ansCnt   = countColor(i_answer, r_idx);
    w_minCnt   = (w_guessCnt < w_ansCnt) ? w_guessCnt : w_ansCnt;
    w_sumNext  = r_sum + w_minCnt;
  end

  assign o_blackDone = (r_phase == SC_BLACK) && (r_idx == 3'd3);
  assign o_done      = (r_phase == SC_WHITE) && (r_idx == 3'(NUM_COLORS));
  assign o_black     = r_black;
  assign o_white     = w_sumNext - r_black;

  // Phase sequencing and accumulation; reset abandons any score in flight.
  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_phase <= SC_IDLE;
      r_idx   <= '0;
      r_black <= '0;
      r_sum   <= '0;
    end else begin
      case (r_phase)
        SC_IDLE: begin
          if (i_start) begin
            r_phase <= SC_BLACK;
            r_idx   <= '0;
            r_black <= '0;
            r_sum   <= '0;
          end
        end
        SC_BLACK: begin
          r_black <= r_black + {2'b00, w_pegMatch};
          if (r_idx == 3'd3) begin
            r_phase <= SC_WHITE;
            r_idx   <= 3'd1;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        SC_WHITE: begin
          r_sum <= w_sumNext;
          if (r_idx == 3'(NUM_COLORS)) begin
            r_phase <= SC_IDLE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 3'd1;
          end
        end
        default: r_phase <= SC_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mastermind_round_ctrl.sv
// Mastermind round controller: guess editing with a peg cursor, fixed-latency
// scoring through mastermind_scorer, feedback/history-row write and the
// win / out-of-guesses end states.
module mastermind_round_ctrl
  import mastermind_pkg::*;
#(
  parameter int MAX_GUESSES = 6
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [CODE_W-1:0] correct_answer,
  input  logic [2:0]        current_color,
  input  logic              confirm_color,
  input  logic              check_guess,
  input  logic              BtnL,
  input  logic              BtnR,
  output logic [CODE_W-1:0] current_guess,
  output logic [1:0]        cursor,
  output logic [2:0]        guess_num,
  output logic [2:0]        black,
  output logic [2:0]        white,
  output logic              fb_valid,
  output logic              wr_en,
  output logic [2:0]        wr_addr,
  output logic [17:0]       wr_data,
  output logic              q_Start,
  output logic              q_Input,
  output logic              q_Score,
  output logic              q_DoneC,
  output logic              q_DoneNC
);

  localparam logic [2:0] LAST_GUESS = 3'(MAX_GUESSES - 1);

  state_t            r_state;
  logic [CODE_W-1:0] r_answer;
  logic [CODE_W-1:0] r_guess;
  logic [1:0]        r_cursor;
  logic [2:0]        r_guessNum;
  logic [2:0]        r_black;
  logic [2:0]        r_white;
  logic              r_fbValid;
  logic              r_wrEn;
  logic [2:0]        r_wrAddr;
  logic [17:0]       r_wrData;

  logic              w_allSet;
  logic              w_start;
  logic              w_blackDone;
  logic              w_scoreDone;
  logic [2:0]        w_black;
  logic [2:0]        w_white;

  // A guess may only be scored once every peg holds a colour.
  always_comb begin
    w_allSet = 1'b1;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if (r_guess[p*COLOR_W +: COLOR_W] == '0) w_allSet = 1'b0;
    end
  end

  assign w_start = (r_state == ST_INPUT) && check_guess && w_allSet;

  mastermind_scorer u_scorer (
    .i_clk       (Clk),
    .i_resetN    (Reset),
    .i_start     (w_start),
    .i_guess     (r_guess),
    .i_answer    (r_answer),
    .o_blackDone (w_blackDone),
    .o_done      (w_scoreDone),
    .o_black     (w_black),
    .o_white     (w_white)
  );

  // Round state machine; pulses are prioritised check > confirm > L > R.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state    <= ST_START;
      r_answer   <= '0;
      r_guess    <= '0;
      r_cursor   <= '0;
      r_guessNum <= '0;
      r_black    <= '0;
      r_white    <= '0;
      r_fbValid  <= 1'b0;
      r_wrEn     <= 1'b0;
      r_wrAddr   <= '0;
      r_wrData   <= '0;
    end else begin
      r_fbValid <= 1'b0;
      r_wrEn    <= 1'b0;
      case (r_state)
        ST_START: begin
          if (confirm_color || check_guess) begin
            r_state    <= ST_INPUT;
            r_answer   <= correct_answer;
            r_guess    <= '0;
            r_cursor   <= '0;
            r_guessNum <= '0;
          end
        end
        ST_INPUT: begin
          if (check_guess) begin
            if (w_allSet) r_state <= ST_SCORE_B;
          end else if (confirm_color) begin
            if (current_color != '0) begin
              r_guess[r_cursor*COLOR_W +: COLOR_W] <= current_color;
              if (r_cursor != 2'd3) r_cursor <= r_cursor + 2'd1;
            end
          end else if (BtnL) begin
            if (r_cursor != 2'd0) r_cursor <= r_cursor - 2'd1;
          end else if (BtnR) begin
            if (r_cursor != 2'd3) r_cursor <= r_cursor + 2'd1;
          end
        end
        ST_SCORE_B: begin
          if (w_blackDone) r_state <= ST_SCORE_W;
        end
        ST_SCORE_W: begin
          if (w_scoreDone) begin
            r_state   <= ST_RESULT;
            r_black   <= w_black;
            r_white   <= w_white;
            r_fbValid <= 1'b1;
            r_wrEn    <= 1'b1;
            r_wrAddr  <= r_guessNum;
            r_wrData  <= {w_white, w_black, r_guess};
          end
        end
        ST_RESULT: begin
          if (r_black == 3'(NUM_PEGS)) begin
            r_state <= ST_DONE_C;
          end else if (r_guessNum == LAST_GUESS) begin
            r_state <= ST_DONE_NC;
          end else begin
            r_guessNum <= r_guessNum + 3'd1;
            r_guess    <= '0;
            r_cursor   <= '0;
            r_state    <= ST_INPUT;
          end
        end
        ST_DONE_C, ST_DONE_NC: begin
          if (check_guess) r_state <= ST_START;
        end
        default: r_state <= ST_START;
      endcase
    end
  end

  assign current_guess = r_guess;
  assign cursor        = r_cursor;
  assign guess_num     = r_guessNum;
  assign black         = r_black;
  assign white         = r_white;
  assign fb_valid      = r_fbValid;
  assign wr_en         = r_wrEn;
  assign wr_addr       = r_wrAddr;
  assign wr_data       = r_wrData;
  assign q_Start       = (r_state == ST_START);
  assign q_Input       = (r_state == ST_INPUT);
  assign q_Score       = (r_state == ST_SCORE_B) || (r_state == ST_SCORE_W) ||
                         (r_state == ST_RESULT);
  assign q_DoneC       = (r_state == ST_DONE_C);
  assign q_DoneNC      = (r_state == ST_DONE_NC);

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Self-checking bench for mastermind_round_ctrl: a table of guesses for a full
// losing game, hand-written sequences for cursor, partial-guess, win, hold and
// mid-score reset cases, and a scoreboard matched against each feedback pulse.
module tb_mastermind_round_ctrl;

  // Edges between the edge that accepts check_guess and the cycle showing fb_valid.
  localparam int FB_EDGES = 10;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [11:0] correct_answer = '0;
  logic [2:0]  current_color = '0;
  logic        confirm_color = 1'b0;
  logic        check_guess = 1'b0;
  logic        BtnL = 1'b0;
  logic        BtnR = 1'b0;
  logic [11:0] current_guess;
  logic [1:0]  cursor;
  logic [2:0]  guess_num;
  logic [2:0]  black;
  logic [2:0]  white;
  logic        fb_valid;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [17:0] wr_data;
  logic        q_Start, q_Input, q_Score, q_DoneC, q_DoneNC;

  mastermind_round_ctrl #(.MAX_GUESSES(6)) dut (
    .Clk(Clk), .Reset(Reset), .correct_answer(correct_answer),
    .current_color(current_color), .confirm_color(confirm_color),
    .check_guess(check_guess), .BtnL(BtnL), .BtnR(BtnR),
    .current_guess(current_guess), .cursor(cursor), .guess_num(guess_num),
    .black(black), .white(white), .fb_valid(fb_valid), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .q_Start(q_Start),
    .q_Input(q_Input), .q_Score(q_Score), .q_DoneC(q_DoneC),
    .q_DoneNC(q_DoneNC)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [11:0] guess;
    logic [2:0]  black;
    logic [2:0]  white;
    logic [2:0]  addr;
    int          edgeN;
  } expect_t;

  typedef struct {
    logic [11:0] guess;
    logic [2:0]  black;
    logic [2:0]  white;
  } vec_t;

  expect_t sbQ[$];
  vec_t    vecs[6];
  int      nChecks = 0;
  int      nFails = 0;
  int      cycleCnt = 0;

  always @(posedge Clk) cycleCnt++;

  function automatic logic [11:0] code(input int p3, input int p2, input int p1, input int p0);
    return {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic cc, input logic chk, input logic l,
                               input logic r, input logic [2:0] col);
    @(negedge Clk);
    confirm_color = cc;
    check_guess   = chk;
    BtnL          = l;
    BtnR          = r;
    current_color = col;
    @(negedge Clk);
    confirm_color = 1'b0;
    check_guess   = 1'b0;
    BtnL          = 1'b0;
    BtnR          = 1'b0;
    current_color = '0;
  endtask

  task automatic pressCheck(input bit push, input logic [11:0] g,
                            input logic [2:0] b, input logic [2:0] w, input logic [2:0] addr);
    expect_t e;
    @(negedge Clk);
    check_guess = 1'b1;
    if (push) begin
      e.guess = g;
      e.black = b;
      e.white = w;
      e.addr  = addr;
      e.edgeN = cycleCnt + 1;
      sbQ.push_back(e);
    end
    @(negedge Clk);
    check_guess = 1'b0;
  endtask

  task automatic enterGuess(input logic [11:0] g);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    for (int p = 0; p < 4; p++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, g[p*3 +: 3]);
    checkOutput("guess_entry", 32'(current_guess), 32'(g));
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while (sbQ.size() != 0 && k < 40) begin
      @(negedge Clk);
      #1;
      k++;
    end
    checkOutput("fb_timeout_pending", 32'(sbQ.size()), 32'd0);
    sbQ.delete();
    @(negedge Clk);
  endtask

  // Every feedback pulse must match the oldest pending scored guess.
  always @(negedge Clk) begin
    expect_t e;
    if (fb_valid === 1'b1 || wr_en === 1'b1) begin
      if (sbQ.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected_fb: fb_valid=%0b wr_en=%0b, expected no write", fb_valid, wr_en);
      end else begin
        e = sbQ.pop_front();
        checkOutput("fb_latency", 32'(cycleCnt - e.edgeN), 32'(FB_EDGES));
        checkOutput("fb_valid", 32'(fb_valid), 32'd1);
        checkOutput("wr_en", 32'(wr_en), 32'd1);
        checkOutput("black", 32'(black), 32'(e.black));
        checkOutput("white", 32'(white), 32'(e.white));
        checkOutput("wr_addr", 32'(wr_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(wr_data), 32'({e.white, e.black, e.guess}));
      end
    end
  end

  initial begin
    logic [11:0] ans;
    ans = code(4, 3, 2, 1);
    // Losing game against answer {4,3,2,1}, one row per guess.
    vecs[0] = '{code(1, 2, 3, 4), 3'd0, 3'd4};
    vecs[1] = '{code(1, 1, 1, 1), 3'd1, 3'd0};
    vecs[2] = '{code(4, 3, 1, 2), 3'd2, 3'd2};
    vecs[3] = '{code(5, 6, 5, 6), 3'd0, 3'd0};
    vecs[4] = '{code(4, 4, 2, 2), 3'd2, 3'd0};
    vecs[5] = '{code(3, 4, 1, 2), 3'd0, 3'd4};

    correct_answer = ans;
    repeat (2) @(negedge Clk);
    checkOutput("rst_q_Start", 32'(q_Start), 32'd1);
    checkOutput("rst_flags", 32'({q_Input, q_Score, q_DoneC, q_DoneNC}), 32'd0);
    checkOutput("rst_fb", 32'({fb_valid, wr_en, black, white}), 32'd0);
    checkOutput("rst_wr", 32'({wr_addr, wr_data}), 32'd0);
    checkOutput("rst_edit", 32'({current_guess, cursor, guess_num}), 32'd0);
    Reset = 1'b1;

    // Game 1: start with confirm, then scramble the answer input mid-game.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    checkOutput("start_q_Input", 32'(q_Input), 32'd1);
    checkOutput("start_guess", 32'(current_guess), 32'd0);
    correct_answer = code(6, 6, 6, 6);

    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    checkOutput("cursor_r_sat", 32'(cursor), 32'd3);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    checkOutput("cursor_l_sat", 32'(cursor), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 3'd5);
    checkOutput("confirm_over_r_cursor", 32'(cursor), 32'd1);
    checkOutput("confirm_over_r_guess", 32'(current_guess), 32'(code(0, 0, 0, 5)));

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd6);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd2);
    checkOutput("partial_guess", 32'(current_guess), 32'(code(0, 2, 6, 5)));
    pressCheck(1'b0, '0, '0, '0, '0);
    repeat (14) @(negedge Clk);
    checkOutput("partial_check_q_Input", 32'(q_Input), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    checkOutput("color0_ignored_guess", 32'(current_guess), 32'(code(0, 2, 6, 5)));
    checkOutput("color0_ignored_cursor", 32'(cursor), 32'd3);

    for (int i = 0; i < 6; i++) begin
      enterGuess(vecs[i].guess);
      pressCheck(1'b1, vecs[i].guess, vecs[i].black, vecs[i].white, 3'(i));
      waitIdle();
      if (i < 5) begin
        checkOutput("next_guess_num", 32'(guess_num), 32'(i + 1));
        checkOutput("next_q_Input", 32'(q_Input), 32'd1);
        checkOutput("next_cleared", 32'({current_guess, cursor}), 32'd0);
      end else begin
        checkOutput("done_nc", 32'(q_DoneNC), 32'd1);
        checkOutput("done_nc_guess_num", 32'(guess_num), 32'd5);
      end
    end

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
    checkOutput("done_nc_holds", 32'(q_DoneNC), 32'd1);
    checkOutput("done_nc_cursor", 32'(cursor), 32'd3);
    checkOutput("done_nc_guess", 32'(current_guess), 32'(vecs[5].guess));
    pressCheck(1'b0, '0, '0, '0, '0);
    checkOutput("done_nc_to_start", 32'(q_Start), 32'd1);
    checkOutput("hold_after_nc", 32'({black, white}), 32'({3'd0, 3'd4}));

    // Game 2: start with check_guess, win on the first guess.
    correct_answer = ans;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    checkOutput("g2_q_Input", 32'(q_Input), 32'd1);
    checkOutput("g2_cleared", 32'({current_guess, cursor, guess_num}), 32'd0);
    enterGuess(code(4, 3, 2, 1));
    pressCheck(1'b1, code(4, 3, 2, 1), 3'd4, 3'd0, 3'd0);
    waitIdle();
    checkOutput("g2_done_c", 32'(q_DoneC), 32'd1);
    pressCheck(1'b0, '0, '0, '0, '0);
    checkOutput("g2_to_start", 32'(q_Start), 32'd1);
    checkOutput("hold_after_c", 32'({black, white}), 32'({3'd4, 3'd0}));

    // Game 3: reset lands mid-score; that score must never be written.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3'd1);
    enterGuess(code(1, 2, 3, 4));
    pressCheck(1'b0, '0, '0, '0, '0);
    repeat (2) @(negedge Clk);
    checkOutput("mid_score_q_Score", 32'(q_Score), 32'd1);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    checkOutput("mid_rst_q_Start", 32'(q_Start), 32'd1);
    checkOutput("mid_rst_fb", 32'({fb_valid, wr_en, black, white}), 32'd0);
    repeat (20) @(negedge Clk);
    checkOutput("mid_rst_stays_start", 32'(q_Start), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
